// File: rtl/aud_dsp_playback.sv
// aud_dsp_playback: SRAM-to-DAC playback engine with fast/slow speed control and linear interpolation
module aud_dsp_playback #(
    parameter int ADDR_W    = 20,
    parameter int MAX_SPEED = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_daclrck,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_fast,
    input  logic              i_slow_0,
    input  logic              i_slow_1,
    input  logic [3:0]        i_speed,
    input  logic [ADDR_W-1:0] i_end_addr,
    output logic [ADDR_W-1:0] o_sram_addr,
    input  logic [15:0]       i_sram_data,
    output logic [15:0]       o_dac_data,
    output logic              o_en,
    output logic              o_done
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] WAIT_LRC = 3'd1;
    localparam logic [2:0] FETCH0   = 3'd2;
    localparam logic [2:0] FETCH1   = 3'd3;
    localparam logic [2:0] DIV      = 3'd4;
    localparam logic [2:0] PAUSE    = 3'd5;
    localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [2:0]        state;
    logic [2:0]        lrc;
    logic              frame;
    logic [ADDR_W:0]   addr, addr_inc, next_addr, end_ext;
    logic [3:0]        k, n, n_in, k_adv;
    logic              fast, slow0, slow1, pause_pend, wt, neg, adv, past, k_wrap, ge;
    logic [15:0]       p, c, qs;
    logic signed [16:0] d;
    logic signed [21:0] prod;
    logic [19:0]       mag, dq;
    logic [3:0]        rem;
    logic [4:0]        r2, cnt;

    assign frame = lrc[1] & ~lrc[2];

    // speed clamp, advance rules, interpolation product and one restoring-divider step
    always_comb begin
        n_in      = (i_speed == 4'd0) ? 4'd1 : (int'(i_speed) > MAX_SPEED) ? 4'(MAX_SPEED) : i_speed;
        end_ext   = {1'b0, i_end_addr};
        addr_inc  = addr + ONE;
        k_wrap    = (k == n - 4'd1);
        next_addr = fast ? addr + {{(ADDR_W-3){1'b0}}, n} : ((slow0 | slow1) && !k_wrap) ? addr : addr_inc;
        k_adv     = (slow0 | slow1) ? (k_wrap ? 4'd0 : k + 4'd1) : k;
        past      = next_addr > end_ext;
        d         = $signed({c[15], c}) - $signed({p[15], p});
        prod      = 22'(d) * 22'($signed({1'b0, k}));
        mag       = prod[21] ? 20'(-prod) : prod[19:0];
        r2        = {rem, dq[19]};
        ge        = r2 >= {1'b0, n};
        qs        = neg ? -dq[15:0] : dq[15:0];
        adv       = (state == FETCH0 && !slow1) || (state == DIV && cnt == 5'd21);
    end

    // two-flop synchronizer on the DAC LR clock plus a history flop for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) lrc <= '0;
        else       lrc <= {lrc[1:0], i_daclrck};
    end

    // playback FSM: fetch, interpolate, advance, and pause/stop handling
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            addr        <= '0;
            k           <= '0;
            n           <= '0;
            fast        <= 1'b0;
            slow0       <= 1'b0;
            slow1       <= 1'b0;
            pause_pend  <= 1'b0;
            wt          <= 1'b0;
            neg         <= 1'b0;
            p           <= '0;
            c           <= '0;
            dq          <= '0;
            rem         <= '0;
            cnt         <= '0;
            o_sram_addr <= '0;
            o_dac_data  <= '0;
            o_en        <= 1'b0;
            o_done      <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_stop) begin
                state       <= IDLE;
                addr        <= '0;
                k           <= '0;
                pause_pend  <= 1'b0;
                o_sram_addr <= '0;
                o_en        <= 1'b0;
                o_dac_data  <= '0;
            end else begin
                if (i_pause && (state == FETCH0 || state == FETCH1 || state == DIV)) pause_pend <= 1'b1;
                case (state)
                    IDLE: begin
                        o_en       <= 1'b0;
                        o_dac_data <= '0;
                        pause_pend <= 1'b0;
                        if (i_start) begin
                            addr        <= '0;
                            k           <= '0;
                            o_sram_addr <= '0;
                            o_en        <= 1'b1;
                            state       <= WAIT_LRC;
                        end
                    end
                    WAIT_LRC: begin
                        o_sram_addr <= addr[ADDR_W-1:0];
                        if (i_pause || pause_pend) begin
                            pause_pend <= 1'b0;
                            o_en       <= 1'b0;
                            o_dac_data <= '0;
                            state      <= PAUSE;
                        end else if (frame) begin
                            fast  <= i_fast;
                            slow1 <= ~i_fast & i_slow_1;
                            slow0 <= ~i_fast & ~i_slow_1 & i_slow_0;
                            n     <= n_in;
                            if (k >= n_in) k <= '0;
                            state <= FETCH0;
                        end
                    end
                    FETCH0: begin
                        p <= i_sram_data;
                        if (!slow1) o_dac_data <= i_sram_data;
                        else if (addr_inc > end_ext) begin
                            c     <= i_sram_data;
                            cnt   <= '0;
                            state <= DIV;
                        end else begin
                            o_sram_addr <= addr_inc[ADDR_W-1:0];
                            wt          <= 1'b1;
                            state       <= FETCH1;
                        end
                    end
                    FETCH1: begin
                        wt <= 1'b0;
                        if (!wt) begin
                            c     <= i_sram_data;
                            cnt   <= '0;
                            state <= DIV;
                        end
                    end
                    DIV: begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd0) begin
                            dq  <= mag;
                            neg <= prod[21];
                            rem <= '0;
                        end else if (cnt <= 5'd20) begin
                            dq  <= {dq[18:0], ge};
                            rem <= ge ? 4'(r2 - {1'b0, n}) : r2[3:0];
                        end else o_dac_data <= p + qs;
                    end
                    PAUSE: begin
                        if (i_start) begin
                            o_en  <= 1'b1;
                            state <= WAIT_LRC;
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (adv) begin
                    addr        <= next_addr;
                    k           <= k_adv;
                    o_sram_addr <= next_addr[ADDR_W-1:0];
                    o_done      <= past;
                    state       <= past ? IDLE : WAIT_LRC;
                end
            end
        end
    end
endmodule

// File: tb/tb_aud_dsp_playback.sv
// tb_aud_dsp_playback: randomized self-checking bench against a sample-sequence reference model
module tb_aud_dsp_playback;
    localparam int ADDR_W = 20;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_daclrck = 1'b0;
    logic              i_start = 1'b0;
    logic              i_pause = 1'b0;
    logic              i_stop = 1'b0;
    logic              i_fast = 1'b0;
    logic              i_slow_0 = 1'b0;
    logic              i_slow_1 = 1'b0;
    logic [3:0]        i_speed = 4'd1;
    logic [ADDR_W-1:0] i_end_addr = '0;
    logic [ADDR_W-1:0] o_sram_addr;
    logic [15:0]       i_sram_data;
    logic [15:0]       o_dac_data;
    logic              o_en;
    logic              o_done;

    logic [15:0] mem [0:63];
    logic [15:0] exp_q [$];
    int asserts = 0;
    int fails = 0;
    int done_cnt = 0;

    aud_dsp_playback #(.ADDR_W(ADDR_W), .MAX_SPEED(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_daclrck(i_daclrck), .i_start(i_start),
        .i_pause(i_pause), .i_stop(i_stop), .i_fast(i_fast), .i_slow_0(i_slow_0),
        .i_slow_1(i_slow_1), .i_speed(i_speed), .i_end_addr(i_end_addr),
        .o_sram_addr(o_sram_addr), .i_sram_data(i_sram_data), .o_dac_data(o_dac_data),
        .o_en(o_en), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;
    always #600 i_daclrck = ~i_daclrck;
    always @(posedge i_clk) i_sram_data <= mem[o_sram_addr[5:0]];
    always @(negedge i_clk) if (o_done) done_cnt++;

    // expected per-frame output list; mode 0 normal, 1 fast, 2 slow hold, 3 slow interpolate
    task automatic build_model(input int mode, input int spd, input int last);
        int nn, p, c;
        nn = (spd == 0) ? 1 : (spd > 8) ? 8 : spd;
        exp_q.delete();
        for (int a = 0; a <= last; a += (mode == 1) ? nn : 1)
            for (int j = 0; j < ((mode >= 2) ? nn : 1); j++) begin
                p = int'($signed(mem[a]));
                c = (a < last) ? int'($signed(mem[a+1])) : p;
                exp_q.push_back((mode == 3) ? 16'(p + (c - p) * j / nn) : mem[a]);
            end
    endtask

    task automatic pulse(input bit s, input bit pz, input bit t);
        @(negedge i_clk);
        i_start = s; i_pause = pz; i_stop = t;
        @(negedge i_clk);
        i_start = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
    endtask

    task automatic grab_frame(output logic [15:0] d, output logic en);
        @(posedge i_daclrck);
        @(negedge i_daclrck);
        repeat (2) @(negedge i_clk);
        d = o_dac_data;
        en = o_en;
    endtask

    task automatic grab_done(output bit seen, output logic [15:0] v, output logic en_a,
                             output logic [15:0] d_a, output logic done_a);
        seen = 1'b0;
        v = '0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge i_clk);
            if (o_done) begin seen = 1'b1; v = o_dac_data; end
        end
        @(negedge i_clk);
        en_a = o_en; d_a = o_dac_data; done_a = o_done;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge i_clk);
        asserts++;
        if (o_dac_data !== 16'd0 || o_en !== 1'b0) begin
            fails++; $display("FAIL reset_data_en: got %h/%b want 0000/0", o_dac_data, o_en);
        end
        asserts++;
        if (o_done !== 1'b0 || o_sram_addr !== '0) begin
            fails++; $display("FAIL reset_done_addr: got %b/%h want 0/0", o_done, o_sram_addr);
        end
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);
        asserts++;
        if (o_en !== 1'b0 || o_dac_data !== 16'd0) begin
            fails++; $display("FAIL idle_after_reset: got en %b data %h want 0/0", o_en, o_dac_data);
        end
    endtask

    task automatic test_modes();
        int mode, spd, last;
        logic [15:0] d, v, d_a;
        logic en, en_a, done_a;
        bit seen;
        for (int s = 0; s < 9; s++) begin
            for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
            case (s)
                0: begin mode = 0; spd = 1; last = 3; for (int i = 0; i < 4; i++) mem[i] = 16'(i * 100); end
                1: begin mode = 1; spd = 3; last = 9; end
                2: begin mode = 2; spd = 4; last = 1; mem[0] = 16'd1000; mem[1] = 16'd2000; end
                3: begin mode = 3; spd = 4; last = 1; mem[0] = 16'd0; mem[1] = 16'hFE70; end
                4: begin mode = 3; spd = 3; last = 1; mem[0] = 16'd0; mem[1] = 16'd100; end
                default: begin mode = $urandom_range(0, 3); spd = $urandom_range(0, 15); last = $urandom_range(1, 4); end
            endcase
            i_fast = (mode == 1);
            i_slow_1 = (mode == 3) || (mode == 1 && $urandom_range(0, 1) == 1);
            i_slow_0 = (mode == 2) || (mode == 3 && $urandom_range(0, 1) == 1);
            i_speed = 4'(spd);
            i_end_addr = ADDR_W'(last);
            build_model(mode, spd, last);
            @(negedge i_daclrck);
            pulse(1, 0, 0);
            for (int i = 0; i < exp_q.size() - 1; i++) begin
                grab_frame(d, en);
                asserts++;
                if (d !== exp_q[i] || en !== 1'b1) begin
                    fails++;
                    $display("FAIL play_s%0d_m%0d_n%0d sample %0d: got %0d en %b want %0d en 1",
                             s, mode, spd, i, $signed(d), en, $signed(exp_q[i]));
                end
            end
            grab_done(seen, v, en_a, d_a, done_a);
            asserts++;
            if (!seen || v !== exp_q[exp_q.size()-1]) begin
                fails++;
                $display("FAIL last_sample_s%0d: done seen %b with %0d want done with %0d",
                         s, seen, $signed(v), $signed(exp_q[exp_q.size()-1]));
            end
            asserts++;
            if (en_a !== 1'b0 || d_a !== 16'd0 || done_a !== 1'b0) begin
                fails++;
                $display("FAIL idle_after_done_s%0d: got en %b data %h done %b want 0/0/0", s, en_a, d_a, done_a);
            end
        end
        i_fast = 1'b0; i_slow_0 = 1'b0; i_slow_1 = 1'b0;
    endtask

    task automatic test_pause_resume();
        logic [15:0] d, v, d_a;
        logic en, en_a, done_a;
        bit seen;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        i_speed = 4'd1;
        i_end_addr = ADDR_W'(5);
        build_model(0, 1, 5);
        @(negedge i_daclrck);
        pulse(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== exp_q[i] || en !== 1'b1) begin
                fails++; $display("FAIL pre_pause sample %0d: got %h en %b want %h en 1", i, d, en, exp_q[i]);
            end
        end
        pulse(0, 1, 0);
        asserts++;
        if (o_en !== 1'b0 || o_dac_data !== 16'd0) begin
            fails++; $display("FAIL pause_entry: got en %b data %h want 0/0", o_en, o_dac_data);
        end
        for (int f = 0; f < 5; f++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== 16'd0 || en !== 1'b0) begin
                fails++; $display("FAIL paused frame %0d: got %h en %b want 0000 en 0", f, d, en);
            end
        end
        pulse(1, 0, 0);
        for (int i = 2; i < 5; i++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== exp_q[i] || en !== 1'b1) begin
                fails++; $display("FAIL resumed sample %0d: got %h en %b want %h en 1", i, d, en, exp_q[i]);
            end
        end
        grab_done(seen, v, en_a, d_a, done_a);
        asserts++;
        if (!seen || v !== exp_q[5] || en_a !== 1'b0) begin
            fails++; $display("FAIL pause_end: done %b data %h en_after %b want 1/%h/0", seen, v, en_a, exp_q[5]);
        end
    endtask

    task automatic test_stop_start();
        logic [15:0] d, v, d_a;
        logic en, en_a, done_a;
        bit seen;
        int dc;
        for (int i = 0; i < 64; i++) mem[i] = 16'($urandom);
        i_speed = 4'd1;
        i_end_addr = ADDR_W'(7);
        build_model(0, 1, 7);
        @(negedge i_daclrck);
        pulse(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== exp_q[i]) begin
                fails++; $display("FAIL pre_stop sample %0d: got %h want %h", i, d, exp_q[i]);
            end
        end
        dc = done_cnt;
        pulse(1, 0, 1);
        asserts++;
        if (o_en !== 1'b0 || o_dac_data !== 16'd0 || o_sram_addr !== '0) begin
            fails++; $display("FAIL stop_state: got en %b data %h addr %h want 0/0/0", o_en, o_dac_data, o_sram_addr);
        end
        for (int f = 0; f < 3; f++) grab_frame(d, en);
        asserts++;
        if (done_cnt != dc || en !== 1'b0 || d !== 16'd0) begin
            fails++; $display("FAIL stop_idle: done pulses %0d en %b data %h want 0/0/0", done_cnt - dc, en, d);
        end
        i_end_addr = ADDR_W'(3);
        build_model(0, 1, 3);
        pulse(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== exp_q[i] || en !== 1'b1) begin
                fails++; $display("FAIL replay sample %0d: got %h en %b want %h en 1", i, d, en, exp_q[i]);
            end
        end
        grab_done(seen, v, en_a, d_a, done_a);
        asserts++;
        if (!seen || v !== exp_q[3]) begin
            fails++; $display("FAIL replay_end: done %b data %h want 1/%h", seen, v, exp_q[3]);
        end
    endtask

    task automatic test_reset_mid_div();
        logic [15:0] d;
        logic en;
        mem[0] = 16'd0;
        mem[1] = 16'hFE70;
        i_slow_1 = 1'b1;
        i_speed = 4'd4;
        i_end_addr = ADDR_W'(1);
        build_model(3, 4, 1);
        @(negedge i_daclrck);
        pulse(1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            grab_frame(d, en);
            asserts++;
            if (d !== exp_q[i]) begin
                fails++; $display("FAIL pre_reset sample %0d: got %h want %h", i, d, exp_q[i]);
            end
        end
        @(posedge i_daclrck);
        repeat (14) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        asserts++;
        if (o_dac_data !== 16'd0 || o_en !== 1'b0 || o_done !== 1'b0 || o_sram_addr !== '0) begin
            fails++; $display("FAIL async_reset: got data %h en %b done %b addr %h want all 0",
                              o_dac_data, o_en, o_done, o_sram_addr);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        i_slow_1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_modes();
        test_pause_resume();
        test_stop_start();
        test_reset_mid_div();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule

// File: doc/aud_dsp_playback.md
Name: aud_dsp_playback

Overview:
- Playback-side sample engine between the audio SRAM and the I2S DAC serializer.
- Once per DAC frame it fetches recorded 16-bit samples from SRAM and applies speed control: normal, fast (skip samples), slow-hold, or slow linear interpolation.
- Presents a stable 16-bit sample plus an enable to the downstream serializer, and reports end-of-playback.

Parameters:
ADDR_W, 20, SRAM word-address width
MAX_SPEED, 8, largest speed factor accepted on i_speed

Ports:
i_clk  input  1  system clock (12 MHz); all logic on rising edge
i_rst  input  1  asynchronous active-high reset
i_daclrck  input  1  DAC LR clock from codec, asynchronous to i_clk
i_start  input  1  one-cycle pulse: start from IDLE, or resume from PAUSE
i_pause  input  1  one-cycle pulse: pause playback
i_stop  input  1  one-cycle pulse: abort playback to IDLE
i_fast  input  1  fast mode select (level)
i_slow_0  input  1  slow mode, sample hold (level)
i_slow_1  input  1  slow mode, linear interpolation (level)
i_speed  input  4  speed factor N; 0 treated as 1, values >MAX_SPEED treated as MAX_SPEED
i_end_addr  input  ADDR_W  address of last valid recorded sample
o_sram_addr  output  ADDR_W  SRAM read address
i_sram_data  input  16  SRAM read data, valid the cycle after o_sram_addr changes
o_dac_data  output  16  sample handed to the serializer (two's complement)
o_en  output  1  high while playing; serializer enable
o_done  output  1  one-cycle pulse when the end of recording is reached

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; address, phase k and sample registers 0.
- i_daclrck passes through a 2-FF synchronizer. A frame event is the synchronized signal going 0->1.
- o_dac_data changes only during the daclrck-high half. It is stable throughout the low half, when the serializer shifts it out.
- Mode priority: i_fast > i_slow_1 > i_slow_0 > normal. Mode and N are sampled at each frame event.
- FSM states: IDLE, WAIT_LRC, FETCH0, FETCH1, DIV, PAUSE.
- IDLE:
  - o_en=0, o_dac_data=0.
  - On i_start: addr=0, k=0, o_en=1, go to WAIT_LRC.
- WAIT_LRC:
  - On i_pause: go to PAUSE.
  - On frame event: drive o_sram_addr=addr and go to FETCH0.
- FETCH0:
  - Capture i_sram_data as P.
  - In slow_1: drive o_sram_addr=addr+1 and go to FETCH1; if addr+1 > i_end_addr, set C=P and skip FETCH1.
  - Otherwise: o_dac_data=P, advance address, return to WAIT_LRC.
- FETCH1:
  - Capture C, go to DIV.
- DIV:
  - Compute D = C - P as 17-bit signed.
  - Compute Q = (D*k)/N, signed, truncated toward zero, using a serial divider of at most 24 cycles.
  - o_dac_data = P + Q, which always fits in 16 bits.
  - Advance, return to WAIT_LRC.
  - Total latency from frame event to o_dac_data update is at most 32 i_clk cycles.
- Advance rules:
  - Normal: addr += 1.
  - Fast: addr += N.
  - slow_0 and slow_1: if k == N-1 then k=0 and addr += 1, else k += 1.
  - Address arithmetic is ADDR_W+1 bits wide, so it cannot wrap.
- End of recording:
  - Checked after each advance: if new addr > i_end_addr, pulse o_done for 1 cycle and go to IDLE.
  - In IDLE, o_en=0 and o_dac_data=0 from the next cycle.
  - The last sample is still output before o_done.
- Change of N while slow: if k >= new N, k resets to 0 without advancing addr.
- PAUSE:
  - o_en=0 and o_dac_data=0; addr and k are held.
  - i_start returns to WAIT_LRC; playback resumes at the held addr and k.
- i_stop in any non-IDLE state:
  - Next cycle: IDLE, addr=0, k=0, o_en=0, o_dac_data=0.
  - No o_done pulse.
  - Stop wins over start or pause in the same cycle.
- i_pause outside WAIT_LRC is latched, and the transition to PAUSE happens on entry to WAIT_LRC.
- i_start while already playing is ignored.
- Asynchronous reset mid-operation returns everything to reset values immediately.

Test Plan:
- Normal: SRAM[i]=i*100, i_end_addr=3, start -> o_dac_data 0,100,200,300 on successive frames; o_done 1 cycle after 300; then o_en=0.
- Fast: i_fast=1, N=3, i_end_addr=9 -> outputs SRAM[0],[3],[6],[9], then o_done.
- Slow_0: N=4, SRAM[0]=1000, SRAM[1]=2000 -> 1000 four times, then 2000 four times.
- Slow_1 with sign and end clamp:
  - N=4, SRAM[0]=0, SRAM[1]=-400 -> 0,-100,-200,-300, then -400.
  - With N=3, 0->100 gives 0,33,66 (truncation toward zero).
  - Last sample interpolates against itself, so it is constant.
- Pause/resume: pause after the second normal sample -> o_en=0 and o_dac_data=0 for 5 frames; start resumes with the third sample, no skip or repeat.
- Stop and start in the same cycle mid-play -> IDLE, addr 0, no o_done; a fresh start replays from SRAM[0]. Asserting i_rst mid-DIV -> all outputs 0 immediately.
